// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Shared definitions for the load/store unit bus adapter:
//             FSM state encoding, load instruction codes, store mask codes
//             and the alignment rule used by the optional misalign check
//             (LSU_MISALIGN_CHECK_EN, see lsu_bus).
//  Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_t;

   // Load instruction codes
   localparam logic [2:0] c_LD_NONE = 3'b000;
   localparam logic [2:0] c_LD_LB   = 3'b001;
   localparam logic [2:0] c_LD_LH   = 3'b010;
   localparam logic [2:0] c_LD_LW   = 3'b011;
   localparam logic [2:0] c_LD_LBU  = 3'b100;
   localparam logic [2:0] c_LD_LHU  = 3'b101;

   // Store byte masks (unshifted)
   localparam logic [3:0] c_ST_NONE = 4'b0000;
   localparam logic [3:0] c_ST_SB   = 4'b0001;
   localparam logic [3:0] c_ST_SH   = 4'b0011;
   localparam logic [3:0] c_ST_SW   = 4'b1111;

   // Halfword accesses need an even address, word accesses a word-aligned
   // one. A nonzero store mask takes precedence over the load code.
   function automatic logic f_misaligned(input logic [2:0] i_ld,
                                         input logic [3:0] i_sm,
                                         input logic [1:0] i_off);
      if (i_sm != c_ST_NONE)
         return ((i_sm == c_ST_SH) && i_off[0]) ||
                ((i_sm == c_ST_SW) && (i_off != 2'b00));
      return (((i_ld == c_LD_LH) || (i_ld == c_LD_LHU)) && i_off[0]) ||
             ((i_ld == c_LD_LW) && (i_off != 2'b00));
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_bus_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_bus_if
//  Purpose  : Bundles the upstream request, downstream result and memory
//             bus signals of the load/store unit.
//  Modports : slave  - the lsu_bus block (accepts requests, drives the bus)
//             master - the surrounding pipeline / memory environment
//  Revision : 1.0 - initial release
// ============================================================================
interface lsu_bus_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   // upstream request
   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] in_addr;
   logic [2:0]            in_load_inst;
   logic [3:0]            in_store_mask;
   logic [DATA_WIDTH-1:0] in_store_data;
   // downstream result
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_rdata;
   logic                  out_err;
   // memory bus
   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic                  mem_wen;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [3:0]            mem_wmask;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_resp_valid;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport slave (
      input  in_valid, in_addr, in_load_inst, in_store_mask, in_store_data,
      output in_ready,
      output out_valid, out_rdata, out_err,
      input  out_ready,
      output mem_req_valid, mem_wen, mem_addr, mem_wmask, mem_wdata,
      input  mem_req_ready, mem_resp_valid, mem_rdata
   );

   modport master (
      output in_valid, in_addr, in_load_inst, in_store_mask, in_store_data,
      input  in_ready,
      input  out_valid, out_rdata, out_err,
      output out_ready,
      input  mem_req_valid, mem_wen, mem_addr, mem_wmask, mem_wdata,
      output mem_req_ready, mem_resp_valid, mem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_load_align
//  Purpose  : Combinational load data alignment: shifts the raw bus word
//             down by the byte offset and sign/zero extends per load type.
//  Ports    : i_rdata     - raw word from the bus
//             i_byte_off  - address bits [1:0]
//             i_load_inst - load code (lsu_pkg c_LD_*)
//             o_data      - aligned, extended result (0 for no load)
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_load_align #(
   parameter int DATA_WIDTH = 32
) (
   input  wire logic [DATA_WIDTH-1:0] i_rdata,
   input  wire logic [1:0]            i_byte_off,
   input  wire logic [2:0]            i_load_inst,
   output logic      [DATA_WIDTH-1:0] o_data
);
   import lsu_pkg::*;

   logic [DATA_WIDTH-1:0] w_shifted;

   assign w_shifted = i_rdata >> {i_byte_off, 3'b000};

   always_comb begin
      o_data = '0;
      case (i_load_inst)
         c_LD_LB:  o_data = {{(DATA_WIDTH-8){w_shifted[7]}},   w_shifted[7:0]};
         c_LD_LH:  o_data = {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
         c_LD_LW:  o_data = w_shifted;
         c_LD_LBU: o_data = {{(DATA_WIDTH-8){1'b0}},           w_shifted[7:0]};
         c_LD_LHU: o_data = {{(DATA_WIDTH-16){1'b0}},          w_shifted[15:0]};
         default:  o_data = '0;
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/lsu_bus.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_bus
//  Purpose  : Single-outstanding load/store unit to memory bus adapter.
//             IDLE accepts a request, REQ presents it on the bus, WAIT takes
//             the response, DONE holds the result until writeback takes it.
//  Ports    : clk, rst  - clock, synchronous active-high reset
//             bus       - lsu_bus_if.slave (upstream, result, memory bus)
//  Config   : LSU_MISALIGN_CHECK_EN - when defined, misaligned halfword/word
//             accesses skip the bus and complete with out_err=1.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_bus #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input wire logic  clk,
   input wire logic  rst,
   lsu_bus_if.slave  bus
);
   import lsu_pkg::*;

   lsu_state_t            r_state;
   lsu_state_t            w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [2:0]            r_load_inst;
   logic [3:0]            r_store_mask;
   logic [DATA_WIDTH-1:0] r_store_data;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_err;

   logic                  w_in_ready;
   logic                  w_req_valid;
   logic                  w_out_valid;
   logic                  w_accept;
   logic                  w_in_noop;
   logic                  w_misalign;
   logic                  w_is_store;
   logic [DATA_WIDTH-1:0] w_load_data;

   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_in_noop  = (bus.in_store_mask == c_ST_NONE) && (bus.in_load_inst == c_LD_NONE);
   // A nonzero store mask wins over any load code.
   assign w_is_store = (r_store_mask != c_ST_NONE);

`ifdef LSU_MISALIGN_CHECK_EN
   assign w_misalign = f_misaligned(bus.in_load_inst, bus.in_store_mask, bus.in_addr[1:0]);
`else
   assign w_misalign = 1'b0;
`endif

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_req_valid = 1'b0;
      w_out_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid)
               w_state_nxt = (w_in_noop || w_misalign) ? ST_DONE : ST_REQ;
         end
         ST_REQ: begin
            w_req_valid = 1'b1;
            if (bus.mem_req_ready) w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.mem_resp_valid) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- request latch and result capture ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr       <= '0;
         r_load_inst  <= c_LD_NONE;
         r_store_mask <= c_ST_NONE;
         r_store_data <= '0;
         r_rdata      <= '0;
         r_err        <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr       <= bus.in_addr;
            r_load_inst  <= bus.in_load_inst;
            r_store_mask <= bus.in_store_mask;
            r_store_data <= bus.in_store_data;
            r_rdata      <= '0;
            r_err        <= w_misalign;
         end
         if ((r_state == ST_WAIT) && bus.mem_resp_valid)
            r_rdata <= w_is_store ? '0 : w_load_data;
      end
   end

   lsu_load_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_load_align (
      .i_rdata     (bus.mem_rdata),
      .i_byte_off  (r_addr[1:0]),
      .i_load_inst (r_load_inst),
      .o_data      (w_load_data)
   );

   // ---------------- outputs ----------------
   // Bus fields come straight from the latched request, so they stay
   // stable for the whole REQ phase however long the bus stalls.
   assign bus.in_ready      = w_in_ready;
   assign bus.out_valid     = w_out_valid;
   assign bus.out_rdata     = r_rdata;
   assign bus.out_err       = r_err;
   assign bus.mem_req_valid = w_req_valid;
   assign bus.mem_wen       = w_is_store;
   assign bus.mem_addr      = {r_addr[ADDR_WIDTH-1:2], 2'b00};
   assign bus.mem_wmask     = r_store_mask << r_addr[1:0];
   assign bus.mem_wdata     = r_store_data << {r_addr[1:0], 3'b000};
endmodule
`default_nettype wire

// File: doc/lsu_bus.md
LSU_BUS -- requirements
Module: lsu_bus

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, giving the data path width.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 32, giving the byte address width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 in_addr  input  ADDR_WIDTH  byte address (ALU result).
REQ-008 in_load_inst  input  3  000 none, 001 lb, 010 lh, 011 lw, 100 lbu, 101 lhu.
REQ-009 in_store_mask  input  4  0000 none, 0001 sb, 0011 sh, 1111 sw.
REQ-010 in_store_data  input  DATA_WIDTH  unshifted store data (rs2).
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream (writeback) accepts the result.
REQ-013 out_rdata  output  DATA_WIDTH  aligned, extended load data; 0 for stores and no-ops.
REQ-014 out_err  output  1  misaligned access flag.
REQ-015 mem_req_valid  output  1  bus request valid.
REQ-016 mem_req_ready  input  1  bus accepts the request.
REQ-017 mem_wen  output  1  1 = write, 0 = read.
REQ-018 mem_addr  output  ADDR_WIDTH  word-aligned address, in_addr with bits [1:0] forced to 0.
REQ-019 mem_wmask  output  4  byte lane enables.
REQ-020 mem_wdata  output  DATA_WIDTH  lane-shifted write data.
REQ-021 mem_resp_valid  input  1  read data or write acknowledge.
REQ-022 mem_rdata  input  DATA_WIDTH  raw word read data.

Function
REQ-023 The FSM SHALL have states IDLE, REQ, WAIT and DONE.
REQ-024 in_ready SHALL be 1 only in IDLE.
REQ-025 On an IDLE accept (in_valid and in_ready), the block SHALL latch addr, load_inst, store_mask and store_data.
REQ-026 From that accept, the next state SHALL be REQ for a memory operation and DONE for a no-op (both fields zero).
REQ-027 If both store_mask and load_inst are nonzero, the block SHALL treat the operation as a store.
REQ-028 In REQ, mem_req_valid SHALL be 1 and the bus outputs SHALL be stable; mem_req_valid and mem_req_ready both high moves the FSM to WAIT.
REQ-029 In WAIT, mem_resp_valid SHALL capture the shifted and extended data and move the FSM to DONE; writes also wait for mem_resp_valid.
REQ-030 In DONE, out_valid SHALL be 1 and out_rdata/out_err SHALL be held stable; out_ready moves the FSM to IDLE.
REQ-031 mem_wmask SHALL be (store_mask << addr[1:0]) truncated to 4 bits, and mem_wdata SHALL be store_data << (8*addr[1:0]).
REQ-032 Load data SHALL be mem_rdata >> (8*addr[1:0]); lb/lh sign-extend, lbu/lhu zero-extend, lw passes through.
REQ-033 Best-case latency SHALL be 3 cycles from accept to out_valid (mem_req_ready=1 in REQ, response in the first WAIT cycle).
REQ-034 mem_resp_valid outside WAIT SHALL be ignored, and mem_req_ready outside REQ SHALL be ignored.
REQ-035 At most one operation SHALL be outstanding at a time; there is no pipelining.

Reset
REQ-036 While rst=1 at a clock edge, the FSM SHALL enter IDLE and clear all latched fields.
REQ-037 Reset values: in_ready=1, out_valid=0, out_rdata=0, out_err=0, mem_req_valid=0, mem_wen=0, mem_addr=0, mem_wmask=0, mem_wdata=0.
REQ-038 Reset in REQ, WAIT or DONE SHALL abandon the operation, and a late mem_resp_valid SHALL be ignored.

Configuration
REQ-039 Macro LSU_MISALIGN_CHECK_EN defined: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0, SHALL skip REQ/WAIT and go to DONE with out_err=1, out_rdata=0, and no bus request.
REQ-040 LSU_MISALIGN_CHECK_EN undefined: out_err SHALL be tied 0 and all accesses SHALL issue, with lane shifting per REQ-031/032.

Structure
REQ-041 Package lsu_pkg SHALL hold the FSM state enum, the load_inst codes and the store_mask codes.
REQ-042 Sub-module lsu_load_align SHALL hold the combinational shift and extend of REQ-032; the FSM and store lane logic stay in lsu_bus.

Verification
REQ-043 lb, addr 0x80000003, mem_rdata 0x80AABBCC -> out_rdata 0xFFFFFF80, out_valid 3 cycles after accept.
REQ-044 lhu, addr 0x80000002, mem_rdata 0xBEEF1234 -> out_rdata 0x0000BEEF.
REQ-045 sb, addr 0x80000001, data 0x000000A5 -> mem_wmask 0010, mem_wdata 0x0000A500, mem_addr 0x80000000, mem_wen=1.
REQ-046 lw with mem_req_ready low 4 cycles and out_ready low 2 cycles -> mem_req_valid and bus outputs stable; out_valid held with out_rdata stable.
REQ-047 rst asserted in WAIT, then a stray mem_resp_valid -> IDLE, out_valid=0, response ignored.
REQ-048 With LSU_MISALIGN_CHECK_EN, sw to addr 0x80000002 -> no mem_req_valid, out_err=1, out_valid 1 cycle after accept.
